// File: rtl/sram_bridge_pkg.sv
// -----------------------------------------------------------------------------
// sram_bridge_pkg
// Shared definitions for the AVR-to-SRAM bridge:
//   - state_e         : access sequencer state encoding
//   - WAIT_CNT_W      : width of the wait-state counter
//   - WAIT_STATES_MAX : largest WAIT_STATES value the counter can hold
// -----------------------------------------------------------------------------
package sram_bridge_pkg;

    localparam int unsigned WAIT_CNT_W      = 4;
    localparam int unsigned WAIT_STATES_MAX = (1 << WAIT_CNT_W) - 1;

    typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SETUP,
        ST_RD_WAIT,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RELEASE
    } state_e;

endpackage : sram_bridge_pkg

// File: rtl/sram_addr_sreg.sv
// -----------------------------------------------------------------------------
// sram_addr_sreg
// SRAM address register, loaded serially MSB first, with an optional
// +1 increment (wraps modulo 2^ADDR_W). Shifting has priority over increment.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   shift_en_i   : shift si_i into the LSB this cycle
//   si_i         : serial address bit
//   inc_en_i     : add one to the address this cycle
//   addr_o       : current address
// -----------------------------------------------------------------------------
module sram_addr_sreg #(
    parameter int unsigned ADDR_W = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en_i,
    input  logic              si_i,
    input  logic              inc_en_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        addr_d = addr_q;
        if (shift_en_i) begin
            addr_d = {addr_q[ADDR_W-2:0], si_i};
        end else if (inc_en_i) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule : sram_addr_sreg

// File: rtl/sram_bridge.sv
// -----------------------------------------------------------------------------
// sram_bridge
// AVR-to-SRAM bus bridge. A serially loaded address register selects the SRAM
// location; a strobe sequencer turns falling AVR read/write strobes into SRAM
// cycles with WAIT_STATES (0..15) extra access cycles. All outputs registered.
//
// Optional feature: define SRAM_BRIDGE_AUTOINC_EN to increment the address
// (modulo 2^ADDR_W) on the edge that completes each access.
//
// Ports:
//   avr_clk, avr_reset_n      : clock (rising edge), async active-low reset
//   avr_si, avr_sreg_en       : serial address bit; 0 = shift, 1 = access
//   avr_oe, avr_we            : active-low read / write requests
//   avr_data_i / avr_data_o   : write data in / read data out
//   avr_data_oe               : drive avr_data_o onto the AVR bus
//   sram_data_i / sram_data_o : SRAM data in / out
//   sram_data_oe              : drive sram_data_o onto the SRAM bus
//   sram_addr                 : SRAM address
//   sram_ce_n/oe_n/we_n       : SRAM strobes, active-low
//   busy                      : sequencer not idle
//   done                      : one-cycle pulse per completed access
// -----------------------------------------------------------------------------
module sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W      = 21,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              avr_clk,
    input  logic              avr_reset_n,
    input  logic              avr_si,
    input  logic              avr_sreg_en,
    input  logic              avr_oe,
    input  logic              avr_we,
    input  logic [DATA_W-1:0] avr_data_i,
    output logic [DATA_W-1:0] avr_data_o,
    output logic              avr_data_oe,
    input  logic [DATA_W-1:0] sram_data_i,
    output logic [DATA_W-1:0] sram_data_o,
    output logic              sram_data_oe,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy,
    output logic              done
);

    localparam wait_cnt_t WAIT_CNT = wait_cnt_t'(WAIT_STATES);

    state_e            state_q, state_d;
    wait_cnt_t         cnt_q, cnt_d;
    logic              oe_smp_q, we_smp_q;
    logic              is_wr_q, is_wr_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              sram_oe_q, sram_oe_d;
    logic [DATA_W-1:0] sram_dat_q, sram_dat_d;
    logic [DATA_W-1:0] avr_dat_q, avr_dat_d;
    logic              avr_oe_q, avr_oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_req, wr_req;
    logic              shift_en, inc_en;

    // A request is a strobe seen low now that was high on the previous edge.
    assign rd_req = oe_smp_q & ~avr_oe;
    assign wr_req = we_smp_q & ~avr_we;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_wr_d    = is_wr_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        sram_oe_d  = sram_oe_q;
        sram_dat_d = sram_dat_q;
        avr_dat_d  = avr_dat_q;
        avr_oe_d   = avr_oe_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Write wins when both strobes fall on the same edge.
                if (avr_sreg_en && wr_req) begin
                    sram_dat_d = avr_data_i;
                    is_wr_d    = 1'b1;
                    state_d    = ST_WR_SETUP;
                end else if (avr_sreg_en && rd_req) begin
                    is_wr_d    = 1'b0;
                    state_d    = ST_RD_SETUP;
                end
            end
            ST_RD_SETUP: begin
                ce_n_d  = 1'b0;
                oe_n_d  = 1'b0;
                cnt_d   = WAIT_CNT;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    avr_dat_d = sram_data_i;
                    avr_oe_d  = 1'b1;
                    ce_n_d    = 1'b1;
                    oe_n_d    = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - wait_cnt_t'(1);
                end
            end
            ST_WR_SETUP: begin
                // Data goes out with chip enable, one cycle ahead of we_n.
                ce_n_d    = 1'b0;
                sram_oe_d = 1'b1;
                cnt_d     = WAIT_CNT;
                state_d   = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                // First cycle here drops we_n; it then stays low for 1+W cycles.
                if (we_n_q) begin
                    we_n_d = 1'b0;
                end else if (cnt_q == '0) begin
                    we_n_d  = 1'b1;
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - wait_cnt_t'(1);
                end
            end
            ST_WR_HOLD: begin
                // Data held one cycle past the rising we_n edge.
                ce_n_d    = 1'b1;
                sram_oe_d = 1'b0;
                done_d    = 1'b1;
                state_d   = ST_RELEASE;
            end
            ST_RELEASE: begin
                ce_n_d    = 1'b1;
                oe_n_d    = 1'b1;
                we_n_d    = 1'b1;
                sram_oe_d = 1'b0;
                if (is_wr_q ? avr_we : avr_oe) begin
                    avr_oe_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge avr_clk or negedge avr_reset_n) begin
        if (!avr_reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            oe_smp_q   <= 1'b1;
            we_smp_q   <= 1'b1;
            is_wr_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            sram_oe_q  <= 1'b0;
            sram_dat_q <= '0;
            avr_dat_q  <= '0;
            avr_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            oe_smp_q   <= avr_oe;
            we_smp_q   <= avr_we;
            is_wr_q    <= is_wr_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            sram_oe_q  <= sram_oe_d;
            sram_dat_q <= sram_dat_d;
            avr_dat_q  <= avr_dat_d;
            avr_oe_q   <= avr_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign shift_en = (state_q == ST_IDLE) && !avr_sreg_en;

`ifdef SRAM_BRIDGE_AUTOINC_EN
    assign inc_en = done_d;
`else
    assign inc_en = 1'b0;
`endif

    sram_addr_sreg #(
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk        (avr_clk),
        .rst_n      (avr_reset_n),
        .shift_en_i (shift_en),
        .si_i       (avr_si),
        .inc_en_i   (inc_en),
        .addr_o     (sram_addr)
    );

    assign avr_data_o   = avr_dat_q;
    assign avr_data_oe  = avr_oe_q;
    assign sram_data_o  = sram_dat_q;
    assign sram_data_oe = sram_oe_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule : sram_bridge

// File: tb/tb_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_sram_bridge
// Two bridges (WAIT_STATES = 1 and 2) driven by the same AVR stimulus, each
// checked against hand-computed per-edge expectations. Edge k below means the
// k-th rising edge after the one that detects the request (edge 0).
// -----------------------------------------------------------------------------
module tb_sram_bridge;

    localparam int unsigned ADDR_W = 21;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              avr_si, avr_sreg_en, avr_oe, avr_we;
    logic [DATA_W-1:0] avr_data_i, sram_data_i;

    logic [DATA_W-1:0] avr_data_o_1, sram_data_o_1, avr_data_o_2, sram_data_o_2;
    logic              avr_data_oe_1, sram_data_oe_1, avr_data_oe_2, sram_data_oe_2;
    logic [ADDR_W-1:0] addr_1, addr_2;
    logic              ce_n_1, oe_n_1, we_n_1, busy_1, done_1;
    logic              ce_n_2, oe_n_2, we_n_2, busy_2, done_2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(1)) u_w1 (
        .avr_clk      (clk),
        .avr_reset_n  (rst_n),
        .avr_si       (avr_si),
        .avr_sreg_en  (avr_sreg_en),
        .avr_oe       (avr_oe),
        .avr_we       (avr_we),
        .avr_data_i   (avr_data_i),
        .avr_data_o   (avr_data_o_1),
        .avr_data_oe  (avr_data_oe_1),
        .sram_data_i  (sram_data_i),
        .sram_data_o  (sram_data_o_1),
        .sram_data_oe (sram_data_oe_1),
        .sram_addr    (addr_1),
        .sram_ce_n    (ce_n_1),
        .sram_oe_n    (oe_n_1),
        .sram_we_n    (we_n_1),
        .busy         (busy_1),
        .done         (done_1)
    );

    sram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(2)) u_w2 (
        .avr_clk      (clk),
        .avr_reset_n  (rst_n),
        .avr_si       (avr_si),
        .avr_sreg_en  (avr_sreg_en),
        .avr_oe       (avr_oe),
        .avr_we       (avr_we),
        .avr_data_i   (avr_data_i),
        .avr_data_o   (avr_data_o_2),
        .avr_data_oe  (avr_data_oe_2),
        .sram_data_i  (sram_data_i),
        .sram_data_o  (sram_data_o_2),
        .sram_data_oe (sram_data_oe_2),
        .sram_addr    (addr_2),
        .sram_ce_n    (ce_n_2),
        .sram_oe_n    (oe_n_2),
        .sram_we_n    (we_n_2),
        .busy         (busy_2),
        .done         (done_2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_in(input logic [ADDR_W-1:0] val);
        avr_sreg_en = 1'b0;
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            avr_si = val[i];
            step();
        end
        avr_sreg_en = 1'b1;
        avr_si      = 1'b0;
    endtask

    logic [ADDR_W-1:0] a_rd, a_wr, a_wrap;

    initial begin
        rst_n       = 1'b0;
        avr_si      = 1'b0;
        avr_sreg_en = 1'b1;
        avr_oe      = 1'b1;
        avr_we      = 1'b1;
        avr_data_i  = '0;
        sram_data_i = 8'hAA;

`ifdef SRAM_BRIDGE_AUTOINC_EN
        a_rd   = 21'h12346;
        a_wr   = 21'h12347;
        a_wrap = 21'h000000;
`else
        a_rd   = 21'h12345;
        a_wr   = 21'h12345;
        a_wrap = 21'h1FFFFF;
`endif

        // Reset values
        #12;
        check("rst_addr", addr_1, 0);
        check("rst_strobes", {ce_n_1, oe_n_1, we_n_1}, 3'b111);
        check("rst_oes", {sram_data_oe_1, avr_data_oe_1}, 2'b00);
        check("rst_busy_done", {busy_1, done_1}, 2'b00);
        check("rst_data", {avr_data_o_1, sram_data_o_1}, 16'h0000);
        step();
        rst_n = 1'b1;

        // Reset in the middle of a write (W=1), asserted just after edge 2
        avr_sreg_en = 1'b0;
        avr_si      = 1'b1;
        repeat (3) step();
        avr_sreg_en = 1'b1;
        avr_si      = 1'b0;
        check("pre_rst_addr", addr_1, 21'h7);
        avr_data_i = 8'h5C;
        avr_we     = 1'b0;
        step();                                    // edge 0
        check("mw_e0_data", sram_data_o_1, 8'h5C);
        step();                                    // edge 1
        check("mw_e1_ce_doe", {ce_n_1, sram_data_oe_1}, 2'b01);
        step();                                    // edge 2
        check("mw_e2_we", we_n_1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mw_rst_strobes", {ce_n_1, oe_n_1, we_n_1}, 3'b111);
        check("mw_rst_doe", sram_data_oe_1, 1'b0);
        check("mw_rst_addr", addr_1, 0);
        avr_we     = 1'b1;
        avr_data_i = '0;
        step();
        rst_n = 1'b1;
        step();

        // Shift in 0x12345, no strobe activity
        shift_in(21'h12345);
        step();
        check("sh_addr_w1", addr_1, 21'h12345);
        check("sh_addr_w2", addr_2, 21'h12345);
        check("sh_idle", {ce_n_1, oe_n_1, we_n_1, busy_1}, 4'b1110);

        // Read, SRAM returns 0xAA
        avr_oe = 1'b0;
        step();                                    // edge 0
        check("rd_e0_busy_oen", {busy_1, oe_n_1}, 2'b11);
        step();                                    // edge 1
        check("rd_e1_ce_oe", {ce_n_1, oe_n_1}, 2'b00);
        step();                                    // edge 2
        check("rd_e2_w1", {oe_n_1, we_n_1, done_1}, 3'b010);
        check("rd_e2_w2", {oe_n_2, done_2}, 2'b00);
        step();                                    // edge 3
        check("rd_e3_w1_done", {oe_n_1, ce_n_1, done_1, avr_data_oe_1}, 4'b1111);
        check("rd_e3_w1_data", avr_data_o_1, 8'hAA);
        check("rd_e3_w1_addr", addr_1, a_rd);
        check("rd_e3_w2_wait", {oe_n_2, done_2}, 2'b00);
        step();                                    // edge 4
        check("rd_e4_w1_rel", {done_1, avr_data_oe_1, busy_1}, 3'b011);
        check("rd_e4_w2_done", {oe_n_2, done_2, avr_data_oe_2}, 3'b111);
        check("rd_e4_w2_data", avr_data_o_2, 8'hAA);
        check("rd_e4_w2_addr", addr_2, a_rd);
        avr_oe = 1'b1;
        step();
        check("rd_rel_w1", {avr_data_oe_1, busy_1}, 2'b00);
        check("rd_rel_w2", {avr_data_oe_2, busy_2}, 2'b00);

        // Write 0xEE; W=2 pulse on edges 2-4, W=1 pulse on edges 2-3
        avr_data_i = 8'hEE;
        avr_we     = 1'b0;
        step();                                    // edge 0
        avr_data_i = 8'h11;
        check("wr_e0_data", sram_data_o_2, 8'hEE);
        step();                                    // edge 1
        check("wr_e1_w2", {ce_n_2, sram_data_oe_2, we_n_2, oe_n_2}, 4'b0111);
        check("wr_e1_data", sram_data_o_2, 8'hEE);
        step();                                    // edge 2
        check("wr_e2_we", {we_n_2, we_n_1}, 2'b00);
        step();                                    // edge 3
        check("wr_e3_w2", {we_n_2, oe_n_2}, 2'b01);
        check("wr_e3_w1", we_n_1, 1'b0);
        step();                                    // edge 4
        check("wr_e4_w2", {we_n_2, ce_n_2, sram_data_oe_2}, 3'b001);
        check("wr_e4_w1", {we_n_1, ce_n_1, sram_data_oe_1}, 3'b101);
        step();                                    // edge 5
        check("wr_e5_w2", {we_n_2, ce_n_2, sram_data_oe_2, done_2}, 4'b1010);
        check("wr_e5_data", sram_data_o_2, 8'hEE);
        check("wr_e5_w1_done", {ce_n_1, sram_data_oe_1, done_1}, 3'b101);
        step();                                    // edge 6
        check("wr_e6_w2_done", {ce_n_2, sram_data_oe_2, done_2, avr_data_oe_2}, 4'b1010);
        check("wr_e6_w2_addr", addr_2, a_wr);
        avr_we = 1'b1;
        step();
        check("wr_rel", {busy_1, busy_2}, 2'b00);

        // Read and write strobes fall together: write only
        avr_data_i = 8'h3C;
        avr_oe     = 1'b0;
        avr_we     = 1'b0;
        step();                                    // edge 0
        step();                                    // edge 1
        check("bo_e1_w2", {ce_n_2, oe_n_2, sram_data_oe_2}, 3'b011);
        step();                                    // edge 2
        check("bo_e2_w2", {oe_n_2, we_n_2}, 2'b10);
        check("bo_e2_data", sram_data_o_2, 8'h3C);
        step();                                    // edge 3
        check("bo_e3_oen", {oe_n_1, oe_n_2}, 2'b11);
        repeat (3) step();                         // edge 6
        check("bo_e6_w2", {done_2, avr_data_oe_2, oe_n_2}, 3'b101);
        avr_oe = 1'b1;
        avr_we = 1'b1;
        step();
        step();
        check("bo_idle", {busy_1, busy_2}, 2'b00);

        // Address wrap on all-ones
        shift_in(21'h1FFFFF);
        step();
        check("wrap_pre", addr_1, 21'h1FFFFF);
        avr_oe = 1'b0;
        repeat (4) step();                         // edge 3
        check("wrap_w1_done", done_1, 1'b1);
        check("wrap_w1_addr", addr_1, a_wrap);
        step();                                    // edge 4
        check("wrap_w2_done", done_2, 1'b1);
        check("wrap_w2_addr", addr_2, a_wrap);
        avr_oe = 1'b1;
        step();
        check("wrap_idle", {busy_1, busy_2}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sram_bridge
